// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder: event layout,
// scan-code-set-2 constants, PS/2 controller register map and FSM states.
package kbd_pkg;

  typedef struct packed {
    logic       sys;
    logic       brk;
    logic       ext;
    logic       perr;
    logic       caps;
    logic       alt;
    logic       ctrl;
    logic       shift;
    logic [7:0] code;
  } kbd_evt_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [3:0] KBD_ADR_CODE = 4'd0;
  localparam logic [3:0] KBD_ADR_STAT = 4'd1;
  localparam logic [7:0] KBD_CLR_DATA = 8'h00;

  // Pause sends E1 followed by seven more bytes that carry no key information.
  localparam logic [2:0] KBD_E1_SKIP = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StRdStat,
    StGap1,
    StRdCode,
    StGap2,
    StClr,
    StDecode,
    StHold
  } kbd_state_e;

  function automatic logic is_sys_code(input logic [7:0] code);
    return code inside {SC_BAT, SC_ACK, SC_RESEND, SC_ERR0, SC_ERR1};
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is kept only when a pop
// happens in the same cycle, otherwise it is dropped and the sticky overflow set.
module kbd_evt_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW-1:0] r_wptr;
  logic [AddrW-1:0] r_rptr;
  logic [CntW-1:0]  r_count;
  logic             r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  assign w_full  = (r_count == CntW'(Depth));
  assign w_empty = (r_count == '0);
  assign w_pop   = pop_i && !w_empty;
  assign w_push  = push_i && (!w_full || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      // A drop in the same cycle as a clear leaves the flag set.
      if (push_i && !w_push) r_ovf <= 1'b1;
      else if (ovf_clr_i)    r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[r_rptr];
  assign empty_o = w_empty;
  assign ovf_o   = r_ovf;

endmodule

// File: rtl/kbd_scan_decoder.sv
// Bus master that fetches scan codes from the PS/2 controller on irq, decodes
// set-2 prefixes and modifiers, and queues 16-bit key events for the CPU.
module kbd_scan_decoder #(
  parameter int unsigned pFifoDepth = 16,
  parameter int unsigned pTimeout   = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        kbd_irq_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_cs_o,
  output logic        m_we_o,
  output logic [3:0]  m_adr_o,
  output logic [7:0]  m_dat_o,
  input  logic        m_ack_i,
  input  logic [7:0]  m_dat_i,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic [15:0] evt_o,
  output logic        irq_o,
  output logic        ovf_o,
  input  logic        ovf_clr_i,
  output logic        tmo_o
);

  import kbd_pkg::*;

  localparam int unsigned TmoW = $clog2(pTimeout + 1);

  kbd_state_e      r_state;
  logic            r_bus;
  logic            r_we;
  logic [3:0]      r_adr;
  logic            r_perr;
  logic [7:0]      r_code;
  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_tmo;

  logic       r_brk, r_ext;
  logic [2:0] r_e1_cnt;
  logic       r_lshift, r_rshift, r_ctrl, r_alt, r_caps;

  logic       w_brk, w_ext;
  logic [2:0] w_e1_cnt;
  logic       w_lshift, w_rshift, w_ctrl, w_alt, w_caps;
  logic       w_push;
  kbd_evt_t   w_evt;
  logic       w_tmo_hit;
  logic       w_empty;

  assign w_tmo_hit = (r_tmo_cnt == TmoW'(pTimeout - 1));

  always_comb begin
    w_push   = 1'b0;
    w_evt    = '0;
    w_brk    = r_brk;
    w_ext    = r_ext;
    w_e1_cnt = r_e1_cnt;
    w_lshift = r_lshift;
    w_rshift = r_rshift;
    w_ctrl   = r_ctrl;
    w_alt    = r_alt;
    w_caps   = r_caps;
    if (r_perr) begin
      w_push    = 1'b1;
      w_evt.sys = 1'b1;
      w_evt.perr = 1'b1;
      w_evt.code = r_code;
      w_brk    = 1'b0;
      w_ext    = 1'b0;
      w_e1_cnt = '0;
    end else if (r_e1_cnt != '0) begin
      w_e1_cnt = r_e1_cnt - 3'd1;
      if (r_e1_cnt == 3'd1) begin
        w_push     = 1'b1;
        w_evt.ext  = 1'b1;
        w_evt.code = SC_E1;
      end
    end else if (r_code == SC_E1) begin
      w_e1_cnt = KBD_E1_SKIP;
    end else if (r_code == SC_E0) begin
      w_ext = 1'b1;
    end else if (r_code == SC_F0) begin
      w_brk = 1'b1;
    end else if (is_sys_code(r_code)) begin
      w_push     = 1'b1;
      w_evt.sys  = 1'b1;
      w_evt.code = r_code;
      w_brk      = 1'b0;
      w_ext      = 1'b0;
    end else begin
      // E0 12 / E0 59 are fake shifts emitted around navigation keys.
      case (r_code)
        SC_LSHIFT: if (!r_ext) w_lshift = !r_brk;
        SC_RSHIFT: if (!r_ext) w_rshift = !r_brk;
        SC_CTRL:   w_ctrl = !r_brk;
        SC_ALT:    w_alt  = !r_brk;
        SC_CAPS:   if (!r_brk) w_caps = !r_caps;
        default:   ;
      endcase
      w_push      = 1'b1;
      w_evt.brk   = r_brk;
      w_evt.ext   = r_ext;
      w_evt.caps  = w_caps;
      w_evt.alt   = w_alt;
      w_evt.ctrl  = w_ctrl;
      w_evt.shift = w_lshift | w_rshift;
      w_evt.code  = r_code;
      w_brk       = 1'b0;
      w_ext       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_bus     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_perr    <= 1'b0;
      r_code    <= '0;
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
      r_brk     <= 1'b0;
      r_ext     <= 1'b0;
      r_e1_cnt  <= '0;
      r_lshift  <= 1'b0;
      r_rshift  <= 1'b0;
      r_ctrl    <= 1'b0;
      r_alt     <= 1'b0;
      r_caps    <= 1'b0;
    end else begin
      r_tmo     <= 1'b0;
      r_tmo_cnt <= (r_bus && !m_ack_i) ? r_tmo_cnt + 1'b1 : '0;
      unique case (r_state)
        StIdle: begin
          if (kbd_irq_i) begin
            r_bus   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= KBD_ADR_STAT;
            r_state <= StRdStat;
          end
        end
        StRdStat, StRdCode, StClr: begin
          if (m_ack_i) begin
            r_bus <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            if (r_state == StRdStat) begin
              r_perr  <= m_dat_i[0];
              r_state <= StGap1;
            end else if (r_state == StRdCode) begin
              r_code  <= m_dat_i;
              r_state <= StGap2;
            end else begin
              r_state <= StDecode;
            end
          end else if (w_tmo_hit) begin
            r_bus   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_tmo   <= 1'b1;
            r_state <= StIdle;
          end
        end
        StGap1: begin
          r_bus   <= 1'b1;
          r_we    <= 1'b0;
          r_adr   <= KBD_ADR_CODE;
          r_state <= StRdCode;
        end
        StGap2: begin
          r_bus   <= 1'b1;
          r_we    <= 1'b1;
          r_adr   <= KBD_ADR_STAT;
          r_state <= StClr;
        end
        StDecode: begin
          r_brk    <= w_brk;
          r_ext    <= w_ext;
          r_e1_cnt <= w_e1_cnt;
          r_lshift <= w_lshift;
          r_rshift <= w_rshift;
          r_ctrl   <= w_ctrl;
          r_alt    <= w_alt;
          r_caps   <= w_caps;
          r_state  <= StHold;
        end
        StHold:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  kbd_evt_fifo #(
    .Depth (pFifoDepth),
    .Width ($bits(kbd_evt_t))
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (w_push && (r_state == StDecode)),
    .data_i    (w_evt),
    .pop_i     (evt_ready_i),
    .data_o    (evt_o),
    .empty_o   (w_empty),
    .ovf_o     (ovf_o),
    .ovf_clr_i (ovf_clr_i)
  );

  assign m_cyc_o     = r_bus;
  assign m_stb_o     = r_bus;
  assign m_cs_o      = r_bus;
  assign m_we_o      = r_we;
  assign m_adr_o     = r_adr;
  assign m_dat_o     = KBD_CLR_DATA;
  assign tmo_o       = r_tmo;
  assign evt_valid_o = !w_empty;
  assign irq_o       = !w_empty;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench: a PS/2 controller slave model feeds scan codes, expected events
// are queued at stimulus time and compared as the consumer pops them.
module tb_kbd_scan_decoder;

  localparam int unsigned Depth = 16;
  localparam int unsigned Tmo   = 255;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        kbd_irq;
  logic        m_cyc_o, m_stb_o, m_cs_o, m_we_o;
  logic [3:0]  m_adr_o;
  logic [7:0]  m_dat_o;
  logic        s_ack = 1'b0;
  logic [7:0]  s_dat = 8'h00;
  logic        evt_valid_o, evt_ready, irq_o, ovf_o, ovf_clr, tmo_o;
  logic [15:0] evt_o;

  logic [7:0]  slave_stat = 8'h00;
  logic [7:0]  slave_code = 8'h00;
  logic        ack_en = 1'b1;
  logic        prev_stb = 1'b0;
  int          clr_cnt = 0;
  int          rise_cnt = 0;
  logic [12:0] bus_log[$];
  logic [15:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  kbd_scan_decoder #(
    .pFifoDepth (Depth),
    .pTimeout   (Tmo)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .kbd_irq_i   (kbd_irq),
    .m_cyc_o     (m_cyc_o),
    .m_stb_o     (m_stb_o),
    .m_cs_o      (m_cs_o),
    .m_we_o      (m_we_o),
    .m_adr_o     (m_adr_o),
    .m_dat_o     (m_dat_o),
    .m_ack_i     (s_ack),
    .m_dat_i     (s_dat),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready),
    .evt_o       (evt_o),
    .irq_o       (irq_o),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr),
    .tmo_o       (tmo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave acks one cycle after strobe; the acked write to the status register clears irq.
  always @(posedge clk) begin
    if (m_cyc_o && m_stb_o && m_cs_o && !s_ack && ack_en) begin
      s_ack <= 1'b1;
      s_dat <= (m_adr_o == 4'd1) ? slave_stat : slave_code;
      bus_log.push_back({m_we_o, m_adr_o, m_dat_o});
    end else begin
      s_ack <= 1'b0;
    end
    if (s_ack && m_cyc_o && m_we_o && m_adr_o == 4'd1) clr_cnt <= clr_cnt + 1;
    if (m_stb_o && !prev_stb) rise_cnt <= rise_cnt + 1;
    prev_stb <= m_stb_o;
  end

  always @(negedge clk) begin
    if (rst_ni && evt_valid_o && evt_ready) begin
      check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("evt", 32'(evt_o), 32'(exp_q.pop_front()));
    end
  end

  task automatic send(input logic [7:0] st, input logic [7:0] code, input bit pop_on_push,
                      output int lat);
    int  start;
    int  tail;
    bit  done;
    start = clr_cnt;
    slave_stat = st;
    slave_code = code;
    lat  = -1;
    tail = -1;
    done = 1'b0;
    kbd_irq = 1'b1;
    for (int n = 1; n <= 600 && !done; n++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && evt_valid_o) lat = n;
      if (pop_on_push && evt_ready) evt_ready = 1'b0;
      if (kbd_irq && clr_cnt != start) begin
        kbd_irq = 1'b0;
        tail = 5;
        if (pop_on_push) evt_ready = 1'b1;
      end else if (tail > 0) begin
        tail--;
        if (tail == 0) done = 1'b1;
      end
    end
    if (!done) check("send_complete", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 100 && (exp_q.size() != 0 || evt_valid_o); n++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_low"}, 32'(evt_valid_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    int r0;
    logic [12:0] exp_bus [3];
    exp_bus[0] = {1'b0, 4'd1, 8'h00};
    exp_bus[1] = {1'b0, 4'd0, 8'h00};
    exp_bus[2] = {1'b1, 4'd1, 8'h00};

    rst_ni = 1'b0;
    kbd_irq = 1'b0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(m_cyc_o), 0);
    check("rst_stb", 32'(m_stb_o), 0);
    check("rst_valid", 32'(evt_valid_o), 0);
    check("rst_evt", 32'(evt_o), 0);
    check("rst_ovf", 32'(ovf_o), 0);
    check("rst_tmo", 32'(tmo_o), 0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single make: bus sequence, event and latency.
    bus_log.delete();
    r0 = rise_cnt;
    evt_ready = 1'b1;
    exp_q.push_back(16'h001C);
    send(8'h00, 8'h1C, 1'b0, lat);
    check("latency_seen", 32'(lat > 0), 1);
    check("latency_le12", 32'(lat <= 12), 1);
    check("bus_count", 32'(bus_log.size()), 3);
    for (int i = 0; i < 3 && i < bus_log.size(); i++) check("bus_access", 32'(bus_log[i]), 32'(exp_bus[i]));
    check("bus_gaps", 32'(rise_cnt - r0), 3);
    drain("make");

    // Extended break.
    send(8'h00, 8'hE0, 1'b0, lat);
    send(8'h00, 8'hF0, 1'b0, lat);
    exp_q.push_back(16'h6075);
    send(8'h00, 8'h75, 1'b0, lat);
    drain("extbrk");

    // Modifiers: shift hold/release, caps toggling on makes only.
    exp_q.push_back(16'h0112); send(8'h00, 8'h12, 1'b0, lat);
    exp_q.push_back(16'h011C); send(8'h00, 8'h1C, 1'b0, lat);
    send(8'h00, 8'hF0, 1'b0, lat);
    exp_q.push_back(16'h4012); send(8'h00, 8'h12, 1'b0, lat);
    exp_q.push_back(16'h0858); send(8'h00, 8'h58, 1'b0, lat);
    send(8'h00, 8'hF0, 1'b0, lat);
    exp_q.push_back(16'h4858); send(8'h00, 8'h58, 1'b0, lat);
    exp_q.push_back(16'h0058); send(8'h00, 8'h58, 1'b0, lat);
    drain("mods");

    // Parity error clears a pending E0.
    send(8'h00, 8'hE0, 1'b0, lat);
    exp_q.push_back(16'h901C); send(8'h81, 8'h1C, 1'b0, lat);
    exp_q.push_back(16'h0075); send(8'h00, 8'h75, 1'b0, lat);
    drain("perr");

    // Overflow: one more make than the FIFO holds.
    evt_ready = 1'b0;
    for (int i = 0; i <= Depth; i++) begin
      if (i < Depth) exp_q.push_back(16'h0020 + 16'(i));
      send(8'h00, 8'h20 + 8'(i), 1'b0, lat);
    end
    check("ovf_set", 32'(ovf_o), 1);
    check("full_head", 32'(evt_o), 32'h0020);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf_o), 0);
    exp_q.push_back(16'h0040);
    send(8'h00, 8'h40, 1'b1, lat);
    check("full_pop_no_ovf", 32'(ovf_o), 0);
    evt_ready = 1'b1;
    drain("ovf");

    // Timeout: slave never acks.
    ack_en = 1'b0;
    slave_stat = 8'h00;
    kbd_irq = 1'b1;
    for (int n = 0; n < 10 && !m_stb_o; n++) begin
      @(posedge clk);
      #1;
    end
    cnt = 0;
    while (!tmo_o && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    kbd_irq = 1'b0;
    check("tmo_cycles", 32'(cnt), 32'(Tmo));
    check("tmo_bus_cyc", 32'(m_cyc_o), 0);
    check("tmo_bus_stb", 32'(m_stb_o), 0);
    @(posedge clk);
    #1;
    check("tmo_pulse", 32'(tmo_o), 0);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_no_evt", 32'(evt_valid_o), 0);
    ack_en = 1'b1;

    // Asynchronous reset in the middle of the scan-code read.
    slave_code = 8'h1C;
    kbd_irq = 1'b1;
    cnt = 0;
    while (!(m_stb_o && m_adr_o == 4'd0) && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("rdcode_reached", 32'(m_stb_o && m_adr_o == 4'd0), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_cyc", 32'(m_cyc_o), 0);
    check("arst_stb", 32'(m_stb_o), 0);
    check("arst_cs", 32'(m_cs_o), 0);
    check("arst_adr", 32'(m_adr_o), 0);
    check("arst_valid", 32'(evt_valid_o), 0);
    kbd_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_idle", 32'(m_cyc_o), 0);
    exp_q.push_back(16'h001C);
    send(8'h00, 8'h1C, 1'b0, lat);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
